iq_pair_scheduler: RTL

Drains the I and Q output FIFOs of the IQ reader in lockstep and issues matched I/Q pairs to one downstream FIFO (demodulator input). It adds start/burst sequencing, integer decimation, and a skew watchdog that halts the stream if the two FIFOs fall out of step. It is the controller between the IQ reader's output FIFOs and the demod stage.

---
 rtl/iq_pair_scheduler.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/iq_pair_scheduler.sv
// iq_pair_scheduler
//   Drains the I and Q output FIFOs of the IQ reader in lockstep and writes
//   matched I/Q pairs into one downstream FIFO (demodulator input). Adds
//   start/burst sequencing, integer decimation (keep 1 of decim+1 pairs) and
//   a skew watchdog that halts the stream if only one FIFO keeps running dry.
//
// Ports
//   clock      system clock, rising edge
//   reset      asynchronous, active-low reset
//   start      level request to stream; dropping it returns RUN/DONE to IDLE
//   decim      decimation factor minus one, sampled on IDLE->RUN
//   burst_len  pairs to emit (0 = continuous), sampled on IDLE->RUN
//   i_empty/q_empty, i_dout/q_dout   first-word-fall-through FIFO heads
//   i_rd_en/q_rd_en                  pop strobes (always identical)
//   out_full, out_wr_en, out_i, out_q  downstream FIFO write side
//   busy/done/skew_err               state is RUN / DONE / HALT
//   out_count  pairs written since the last IDLE->RUN transition
module iq_pair_scheduler #(
  parameter int DATA_SIZE  = 32,
  parameter int DECIM_BITS = 4,
  parameter int BURST_BITS = 16,
  parameter int SKEW_LIMIT = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DECIM_BITS-1:0] decim,
  input  logic [BURST_BITS-1:0] burst_len,
  input  logic                  i_empty,
  input  logic                  q_empty,
  input  logic [DATA_SIZE-1:0]  i_dout,
  input  logic [DATA_SIZE-1:0]  q_dout,
  output logic                  i_rd_en,
  output logic                  q_rd_en,
  input  logic                  out_full,
  output logic                  out_wr_en,
  output logic [DATA_SIZE-1:0]  out_i,
  output logic [DATA_SIZE-1:0]  out_q,
  output logic                  busy,
  output logic                  done,
  output logic                  skew_err,
  output logic [BURST_BITS-1:0] out_count
);

  localparam int SKEW_W = $clog2(SKEW_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic [DECIM_BITS-1:0]   decim_reg;
  logic [BURST_BITS-1:0]   burst_reg;
  logic [BURST_BITS-1:0]   out_count_reg;
  logic [DECIM_BITS-1:0]   dec_cnt_reg;
  logic [SKEW_W-1:0]       skew_cnt_reg;
  logic [DATA_SIZE-1:0]    last_i_reg, last_q_reg;

  logic                    running;
  logic                    both_avail;
  logic                    keep;
  logic                    pop;
  logic                    wr;
  logic                    skewed;
  logic                    skew_hit;
  logic                    burst_hit;
  logic [BURST_BITS-1:0]   count_inc;

  always_comb begin
    running    = (state_reg == ST_RUN);
    both_avail = !i_empty && !q_empty;
    keep       = (dec_cnt_reg == '0);
    // Discarded pairs never wait on out_full; kept pairs stall on it.
    pop        = running && both_avail && (!keep || !out_full);
    wr         = pop && keep;
    skewed     = running && (i_empty ^ q_empty);
    skew_hit   = skewed && (skew_cnt_reg == SKEW_W'(SKEW_LIMIT - 1));
    count_inc  = out_count_reg + 1'b1;
    burst_hit  = (burst_reg != '0) && wr && (count_inc == burst_reg);
  end

  // Next-state: HALT beats burst completion, which beats a dropped start.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN: begin
        if (skew_hit)       state_next = ST_HALT;
        else if (burst_hit) state_next = ST_DONE;
        else if (!start)    state_next = ST_IDLE;
      end
      ST_DONE: if (!start) state_next = ST_IDLE;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      decim_reg     <= '0;
      burst_reg     <= '0;
      out_count_reg <= '0;
      dec_cnt_reg   <= '0;
      skew_cnt_reg  <= '0;
      last_i_reg    <= '0;
      last_q_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && start) begin
        decim_reg     <= decim;
        burst_reg     <= burst_len;
        out_count_reg <= '0;
        dec_cnt_reg   <= '0;
        skew_cnt_reg  <= '0;
      end
      if (pop) begin
        dec_cnt_reg <= (dec_cnt_reg == decim_reg) ? '0 : dec_cnt_reg + 1'b1;
      end
      if (wr) begin
        out_count_reg <= count_inc;
        last_i_reg    <= i_dout;
        last_q_reg    <= q_dout;
      end
      if (running) begin
        skew_cnt_reg <= skewed ? skew_cnt_reg + 1'b1 : '0;
      end
    end
  end

  // FIFO heads pass straight through on a write; otherwise the last written
  // pair is held so downstream sees stable data.
  assign i_rd_en   = pop;
  assign q_rd_en   = pop;
  assign out_wr_en = wr;
  assign out_i     = wr ? i_dout : last_i_reg;
  assign out_q     = wr ? q_dout : last_q_reg;
  assign busy      = (state_reg == ST_RUN);
  assign done      = (state_reg == ST_DONE);
  assign skew_err  = (state_reg == ST_HALT);
  assign out_count = out_count_reg;

endmodule
